shift_sched: RTL

Two-client scheduler for the ALU's shared 32-bit barrel `Shifter`. It arbitrates round-robin between two requesters and registers the selected operands. It maps SLL, SRL and SRA onto the single right-logical `Shifter` by bit reversal and sign fill. The result is returned through a valid/ready response port. It sits between the ALU control decode and the shifter datapath.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/shift_sched_shifter.sv | 25 ++
 rtl/shift_sched.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU shift codes, scheduler state encoding, bit-reverse helper
//
// Purpose: constants shared between the ALU decode and the shift scheduler.
//   WIDTH          operand/result width of the shared Shifter
//   SLL/SRL/SRA    Signal codes for the three supported shifts
//   state_t        scheduler FSM encoding
//   bitrev()       reverses a WIDTH-bit word; lets a right shifter shift left
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [5:0] SLL = 6'b000000;
  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] SRA = 6'b000011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = x[WIDTH-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_sched_shifter.sv
// rtl/shift_sched_shifter.sv - shared 32-bit right-logical barrel shifter
//
// Purpose: combinational logical right shift; the ALU's single shared shifter.
// Ports:
//   reset    in   1   active-high clear of the output (callers normally tie 0)
//   dataA    in   32  value to shift
//   dataB    in   5   shift amount
//   dataOut  out  32  dataA >> dataB, zero filled
module Shifter
  import alu_pkg::*;
(
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [4:0]       dataB,
  output logic [WIDTH-1:0] dataOut
);

  always_comb begin
    dataOut = '0;
    if (!reset) begin
      dataOut = dataA >> dataB;
    end
  end

endmodule

// File: rtl/shift_sched.sv
// rtl/shift_sched.sv - two-client round-robin scheduler for the shared Shifter
//
// Purpose: arbitrates two requesters, latches the granted operands, maps
// SLL/SRL/SRA onto the right-logical Shifter and returns a registered result.
// Ports:
//   clk, reset                 clock; synchronous active-low reset
//   reqN_valid/ready           request handshake for client N (0,1)
//   reqN_dataA/dataB/Signal    operand, shift amount ([4:0] used), op code
//   out_valid/ready            result handshake
//   out_dataOut/id/err         result, issuing client, unsupported-code flag
//   busy                       scheduler is not idle
module shift_sched
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_dataA,
  input  logic [WIDTH-1:0] req0_dataB,
  input  logic [5:0]       req0_Signal,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_dataA,
  input  logic [WIDTH-1:0] req1_dataB,
  input  logic [5:0]       req1_Signal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_dataOut,
  output logic             out_id,
  output logic             out_err,
  output logic             busy
);

  state_t           state, state_nx;
  logic             last_id;
  logic [WIDTH-1:0] a_q;
  logic [4:0]       sh_q;
  logic [5:0]       sig_q;
  logic             id_q;

  logic             gnt0, gnt1, accept;
  logic [WIDTH-1:0] sh_in, sh_out, fill, res;
  logic             err;

  // Only the low five bits of the shift amount matter.
  logic unused_dataB_hi;
  assign unused_dataB_hi = ^{req0_dataB[WIDTH-1:5], req1_dataB[WIDTH-1:5]};

  // Round robin: on contention the client that did not win last time goes.
  always_comb begin
    gnt1 = req1_valid && (!req0_valid || !last_id);
    gnt0 = req0_valid && !gnt1;
  end

  // Readies are gated by reset so nothing is accepted while reset is held.
  assign accept     = reset && (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && gnt0;
  assign req1_ready = accept && gnt1;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req0_valid || req1_valid) state_nx = EXEC;
      EXEC:    state_nx = DONE;
      DONE:    if (out_valid && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Left shifts ride the right shifter by reversing bits on both sides.
  assign sh_in = (sig_q == SLL) ? bitrev(a_q) : a_q;

  Shifter u_shifter (
    .reset   (1'b0),
    .dataA   (sh_in),
    .dataB   (sh_q),
    .dataOut (sh_out)
  );

  // Top sh_q bits set: the positions vacated by an arithmetic right shift.
  assign fill = ~({WIDTH{1'b1}} >> sh_q);

  always_comb begin
    res = '0;
    err = 1'b0;
    case (sig_q)
      SRL:     res = sh_out;
      SLL:     res = bitrev(sh_out);
      SRA:     res = a_q[WIDTH-1] ? (sh_out | fill) : sh_out;
      default: err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      last_id     <= 1'b1;
      a_q         <= '0;
      sh_q        <= '0;
      sig_q       <= '0;
      id_q        <= 1'b0;
      out_valid   <= 1'b0;
      out_dataOut <= '0;
      out_id      <= 1'b0;
      out_err     <= 1'b0;
    end else begin
      state <= state_nx;
      if (req0_ready || req1_ready) begin
        last_id <= gnt1;
        id_q    <= gnt1;
        a_q     <= gnt1 ? req1_dataA       : req0_dataA;
        sh_q    <= gnt1 ? req1_dataB[4:0]  : req0_dataB[4:0];
        sig_q   <= gnt1 ? req1_Signal      : req0_Signal;
      end
      if (state == EXEC) begin
        out_valid   <= 1'b1;
        out_dataOut <= res;
        out_id      <= id_q;
        out_err     <= err;
      end else if (state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
